// File: rtl/upsample_nn.sv
// upsample_nn: streaming 2x nearest-neighbour upsampler.
// Accepts a raster-order DIM x DIM map of signed pixels and emits a
// raster-order 2DIM x 2DIM map. Each pixel is sent twice (horizontal
// replication). Each row is then replayed from a line buffer (vertical
// replication).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pxl_in/in_valid     input pixel stream; in_ready is the accept signal
//   pxl_out/out_valid   registered output pixel stream; out_ready is the
//                       downstream accept signal
//   out_sof/out_eof     first / last output pixel of a frame
module upsample_nn #(
    parameter int DIM = 14,
    parameter int PP  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [PP:0]   pxl_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [PP:0]   pxl_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sof,
    output logic          out_eof
);

    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic {ROW_A, ROW_B} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [CW-1:0]  row_q, row_d;
    logic           rep_q, rep_d;
    logic           out_valid_q, out_valid_d;
    logic           sof_q, sof_d;
    logic           eof_q, eof_d;
    logic [PP:0]    pxl_q, pxl_d;
    logic [PP:0]    line_buf_q [DIM];

    logic           free;
    logic           in_xfer;
    logic           load;
    logic           out_xfer;
    logic           col_last;
    logic           row_last;
    logic           buf_we;

    always_comb begin
        // The output register can take a new pixel when it is empty, or
        // when its second copy leaves in this cycle.
        free     = !out_valid_q || (out_ready && rep_q);
        in_ready = !reset && (state_q == ROW_A) && free;
        in_xfer  = in_valid && in_ready;
        load     = (state_q == ROW_A) ? in_xfer : free;
        out_xfer = out_valid_q && out_ready;
        col_last = (col_q == CW'(DIM - 1));
        row_last = (row_q == CW'(DIM - 1));
        buf_we   = (state_q == ROW_A) && in_xfer;

        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        rep_d       = rep_q;
        out_valid_d = out_valid_q;
        sof_d       = sof_q;
        eof_d       = eof_q;
        pxl_d       = pxl_q;

        if (load) begin
            // A new load replaces a draining second copy with no bubble.
            pxl_d       = (state_q == ROW_A) ? pxl_in : line_buf_q[col_q];
            out_valid_d = 1'b1;
            rep_d       = 1'b0;
            sof_d       = (state_q == ROW_A) && (row_q == '0) && (col_q == '0);
            eof_d       = (state_q == ROW_B) && row_last && col_last;
            col_d       = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                if (state_q == ROW_A) begin
                    state_d = ROW_B;
                end else begin
                    state_d = ROW_A;
                    row_d   = row_last ? '0 : row_q + 1'b1;
                end
            end
        end else if (out_xfer) begin
            if (!rep_q) begin
                rep_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ROW_A;
            col_q       <= '0;
            row_q       <= '0;
            rep_q       <= 1'b0;
            out_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            pxl_q       <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rep_q       <= rep_d;
            out_valid_q <= out_valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            pxl_q       <= pxl_d;
        end
    end

    // The line buffer is not reset. Every entry is written in ROW_A before
    // it is read in ROW_B.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf_q[col_q] <= pxl_in;
        end
    end

    assign pxl_out   = pxl_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_valid_q && sof_q && !rep_q;
    assign out_eof   = out_valid_q && eof_q && rep_q;

endmodule

// File: doc/upsample_nn.md
# upsample_nn

Streaming 2x nearest-neighbour upsampler for the CNN datapath. It is the inverse of the 2x2/stride-2 pooling stage: it accepts a raster-order DIM x DIM feature map of signed pixels and emits a raster-order 2DIM x 2DIM map. Each input pixel is replicated horizontally, and each row is replayed vertically from an internal line buffer. Ready/valid handshakes on both sides allow it to sit between pooling/conv stages and a frame sink.

## Interface
- DIM, 14: input image rows/columns; output is 2*DIM x 2*DIM.
- PP, 8: pixel precision MSB index; pixels are signed [PP:0] (PP+1 bits).
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- pxl_in  in  PP+1  signed input pixel, raster order.
- in_valid  in  1  pxl_in is valid.
- in_ready  out  1  block accepts pxl_in this cycle.
- pxl_out  out  PP+1  signed output pixel, registered.
- out_valid  out  1  pxl_out is valid.
- out_ready  in  1  downstream accepts pxl_out this cycle.
- out_sof  out  1  marks output pixel (0,0) of a frame.
- out_eof  out  1  marks output pixel (2DIM-1, 2DIM-1) of a frame.

## Operation
- Input transfer: in_valid && in_ready at posedge. Output transfer: out_valid && out_ready at posedge.
- State: FSM {ROW_A, ROW_B}; col counter 0..DIM-1; row counter 0..DIM-1; rep bit (0 = first copy, 1 = second copy).
- Storage: line_buf[DIM] of PP+1 bits, asynchronous read, not reset.
- free = !out_valid || (out_ready && rep).
- ROW_A:
  - in_ready = free.
  - On input transfer: pxl_out <= pxl_in; line_buf[col] <= pxl_in; out_valid <= 1; rep <= 0; col++.
  - sof_r <= (row==0 && col==0).
  - On acceptance at col==DIM-1: col <= 0; state <= ROW_B.
- ROW_B:
  - in_ready = 0.
  - When free: pxl_out <= line_buf[col]; out_valid <= 1; rep <= 0; col++.
  - eof_r <= (row==DIM-1 && col==DIM-1).
  - After loading col==DIM-1: col <= 0; state <= ROW_A; row <= (row==DIM-1) ? 0 : row+1.
- Output transfer with rep==0: rep <= 1; pxl_out held (second copy).
- Output transfer with rep==1 and no new load in that cycle: out_valid <= 0.
- Drain of a second copy and a new load in the same cycle: the new pixel replaces it, out_valid stays 1, no bubble.
- out_sof = out_valid && sof_r && !rep. out_eof = out_valid && eof_r && rep. sof_r and eof_r are cleared on every load unless set.
- Values are passed bit-exact; there is no arithmetic and no sign change.
- Frame wrap: after the eof pixel, the next input accepted is frame pixel (0,0) and produces sof.

## Timing
- Reset values: pxl_out=0, out_valid=0, out_sof=0, out_eof=0, in_ready=0 while reset is asserted; state=ROW_A, row=col=rep=0.
- in_ready=1 in the first cycle after reset deasserts.
- Latency: a pixel accepted at edge N appears on pxl_out after edge N (same cycle out_valid=1). Its second copy appears after the first output transfer.
- With out_ready=1 and in_valid=1 continuously:
  - ROW_A: in_ready alternates 1,0; 2DIM outputs in 2DIM cycles.
  - ROW_B: 2DIM outputs in 2DIM cycles with in_ready=0.
  - Full output rate is 1 pixel/cycle: 4*DIM*DIM cycles per frame.
- out_ready=0: pxl_out, out_valid, out_sof, out_eof, rep and the FSM hold; in_ready=0 whenever out_valid=1.
- in_valid=0 in ROW_A inserts output bubbles only after the pending second copy drains. ROW_B progress is independent of in_valid.
- Reset mid-frame: the partial frame is discarded and outputs return to reset values next cycle.

## Test plan
- Reset: assert reset 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, pxl_out=0; first cycle after release in_ready=1.
- DIM=2, out_ready=1, inputs 1,2,3,4 -> pxl_out 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4 in 16 consecutive cycles after first accept. out_sof on output 0 only, out_eof on output 15 only.
- DIM=14 full rate, two back-to-back frames of a ramp 0..195 -> 784 outputs per frame with no bubbles. in_ready pattern is 1,0 x14 then 0 x28 per row pair. Output (r,c) = input(r/2, c/2). sof/eof once per frame.
- Backpressure: DIM=2, out_ready=0 for 5 cycles while the first copy of pixel 2 is valid -> pxl_out stays 2, in_ready=0, no duplication or loss; the sequence resumes identically.
- Sign: inputs -256, -1, 255, 0 (PP=8) -> identical signed values replicated, MSB preserved.
- Reset after 5 of 16 inputs (DIM=4) -> a new frame started afterwards outputs its first pixel with out_sof=1 and matches the golden model exactly.
